// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and stall-slice decode for the generalised pipeline stage register.
package pipe_stage_reg_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam int STALL_W_DEF  = 6;
    localparam int STAGE_IF_ID  = 1;
    localparam int STAGE_ID_EX  = 2;
    localparam int STAGE_EX_MEM = 3;
    localparam int STAGE_MEM_WB = 4;

    typedef enum logic [1:0] {
        OP_ADVANCE = 2'd0,
        OP_BUBBLE  = 2'd1,
        OP_HOLD    = 2'd2
    } stage_op_e;

    // up = own stage stalled, dn = downstream stage stalled
    function automatic stage_op_e decode_op(input logic up, input logic dn);
        if (up == NoStop) begin
            return OP_ADVANCE;
        end else if (dn == Stop) begin
            return OP_HOLD;
        end else begin
            return OP_BUBBLE;
        end
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage's bubble and hold statistics.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload + valid, stall-slice decode, flush, optional skid entry.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int STAGE   = STAGE_IF_ID,
    parameter int STALL_W = STALL_W_DEF,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    input  logic [DATA_W-1:0]  in_data_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    output logic [DATA_W-1:0]  out_data_o,
    output logic               skid_full_o,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic [CNT_W-1:0]   hold_cnt_o
);

    localparam bit HasSkid = (SKID != 0);

    logic      up;
    logic      dn;
    stage_op_e op;
    logic      stall_unused;

    assign up = stall_i[STAGE];
    assign dn = stall_i[STAGE+1];
    assign op = decode_op(up, dn);
    // Only the two bits of our own slice matter; the rest belong to other stages.
    assign stall_unused = ^stall_i;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              skid_full_q, skid_full_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            skid_full_d = 1'b0;
            skid_data_d = '0;
        end else begin
            unique case (op)
                OP_ADVANCE: begin
                    if (skid_full_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = skid_data_q;
                        skid_full_d = 1'b0;
                        skid_data_d = '0;
                    end else begin
                        out_valid_d = in_valid_i;
                        out_data_d  = in_valid_i ? in_data_i : '0;
                    end
                end
                OP_BUBBLE: begin
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                end
                default: ;
            endcase
            // A producer that cannot hold its output parks one word here while we stall.
            if (HasSkid && (op != OP_ADVANCE) && in_valid_i && !skid_full_q) begin
                skid_full_d = 1'b1;
                skid_data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready_o  = HasSkid ? (!skid_full_q && !flush_i) : (!up && !flush_i);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign skid_full_o = skid_full_q;

    logic bubble_inc;
    logic hold_inc;

    assign bubble_inc = !flush_i && (op == OP_BUBBLE);
    assign hold_inc   = !flush_i && (op == OP_HOLD);

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (bubble_inc),
        .count_o (bubble_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (hold_inc),
        .count_o (hold_cnt_o)
    );

endmodule
